// File: rtl/avd_sched_pkg.sv
// Shared definitions for the attitude-datapath functional-unit scheduler.
//
// Contents:
//   - default sizing constants (channel count, data width, watchdog limit)
//   - sequencer state enum and matching fixed-width state constants
//   - channel-index type for the default channel count
package avd_sched_pkg;

    localparam int N_REQ_DEF       = 3;
    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    // Plain-vector forms of the state encoding, used by the sequencer's
    // state register so the encoding stays fixed and visible.
    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_ISSUE = S_ISSUE;
    localparam logic [1:0] ST_WAIT  = S_WAIT;
    localparam logic [1:0] ST_RESP  = S_RESP;

    typedef logic [$clog2(N_REQ_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/avd_fu_arbiter_picker.sv
// Round-robin request picker (combinational).
//
// Ports:
//   req        in   N_REQ  request bits
//   ptr        in   IDX_W  highest-priority channel for this search
//   found      out  1      at least one request bit set
//   grant_oh   out  N_REQ  one-hot grant (all zero when nothing found)
//   grant_idx  out  IDX_W  index form of the grant (0 when nothing found)
module avd_rr_picker
    import avd_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    // Two passes: first the channels at or above ptr, then the wrapped-around
    // channels below ptr. The first hit in that order wins.
    always_comb begin
        found     = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/avd_fu_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle functional unit
// among the attitude-axis channels.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-channel request handshake; req_ready is
//                         combinational and only ever set in IDLE
//   req_opa/req_opb       packed operands, channel i at [i*DATA_W +: DATA_W]
//   rsp_valid             one-hot, one-cycle response pulse
//   rsp_data/rsp_err      result and timeout flag, qualified by rsp_valid
//   fu_start              one-cycle FU launch pulse
//   fu_opa/fu_opb         FU operands, held until the next accept
//   fu_done/fu_result     FU completion pulse and result
//   busy                  high whenever the sequencer is not in IDLE
//   grant_idx             channel that currently owns the FU
//
// Handshake: a request on channel i transfers in any cycle where
// req_valid[i] && req_ready[i]; requests dropped before that are lost.
module avd_fu_arbiter
    import avd_sched_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_opa,
    input  logic [N_REQ*DATA_W-1:0]    req_opb,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       fu_start,
    output logic [DATA_W-1:0]          fu_opa,
    output logic [DATA_W-1:0]          fu_opb,
    input  logic                       fu_done,
    input  logic [DATA_W-1:0]          fu_result,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [WD_W-1:0]   wdog;

    logic              pick_found;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] sel_opa;
    logic [DATA_W-1:0] sel_opb;
    logic [N_REQ-1:0]  owner_oh;

    avd_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr),
        .found     (pick_found),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    // One-hot operand mux driven by the picker's grant.
    always_comb begin
        sel_opa = '0;
        sel_opb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_opa = sel_opa | req_opa[i*DATA_W +: DATA_W];
                sel_opb = sel_opb | req_opb[i*DATA_W +: DATA_W];
            end
        end
    end

    // Owner of the in-flight operation, used to steer the response pulse.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_oh[i] = (grant_idx == IDX_W'(i));
        end
    end

    assign req_ready = (state == ST_IDLE) ? pick_oh : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            wdog      <= '0;
            fu_start  <= 1'b0;
            fu_opa    <= '0;
            fu_opb    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            grant_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        fu_opa    <= sel_opa;
                        fu_opb    <= sel_opb;
                        grant_idx <= pick_idx;
                        fu_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fu_start <= 1'b0;
                    wdog     <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // fu_done is tested first so a completion landing on the
                    // last watchdog cycle still returns a good result.
                    if (fu_done) begin
                        rsp_data  <= fu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= owner_oh;
                        state     <= ST_RESP;
                    end else if (wdog == WD_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= owner_oh;
                        state     <= ST_RESP;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    ptr       <= (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
